// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the MAR/MDR memory responder.
// Optional feature macro: MEM_PARITY_EN (per-word even parity).
package cpu_mem_pkg;

    localparam int MEM_DATA_W = 32;
    localparam int MEM_ADDR_W = 9;
    localparam int MEM_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE,
        ST_RELEASE
    } mem_state_t;

    function automatic logic even_par(
        input logic [MEM_DATA_W-1:0] d
    );
        return ^d;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Read/Write strobe + MFC handshake between control unit and memory.
// master = control unit / datapath, slave = memory responder.
interface mem_responder_if
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int ADDR_W = MEM_ADDR_W
) ();

    logic              Read;
    logic              Write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] Mdatain;
    logic              MFC;
    logic              busy;
    logic              parity_err;

    modport master (
        output Read, Write, addr, wdata,
        input  Mdatain, MFC, busy, parity_err
    );

    modport slave (
        input  Read, Write, addr, wdata,
        output Mdatain, MFC, busy, parity_err
    );

endinterface

// File: rtl/mem_array.sv
// Synchronous single-port RAM with write enable and registered read port.
// Read register is reset so the MDR input starts at zero; contents are not.
module mem_array #(
    parameter int W  = 32,
    parameter int AW = 9
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clock) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: strobe capture, wait-state FSM, MFC pulse, RAM access.
// Define MEM_PARITY_EN to store and check one even-parity bit per word.
module mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W      = MEM_DATA_W,
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int WAIT_STATES = 1
) (
    input logic            clock,
    input logic            clear,
    mem_responder_if.slave bus
);

`ifdef MEM_PARITY_EN
    localparam int RW = DATA_W + 1;
`else
    localparam int RW = DATA_W;
`endif

    mem_state_t           state;
    logic [MEM_CNT_W-1:0] cnt;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wd_q;
    logic                 wr_q;
    logic                 mfc_q;
    logic                 busy_q;

    logic                 ram_en;
    logic [RW-1:0]        ram_wd;
    logic [RW-1:0]        ram_q;

    // RAM is touched only in the last ACCESS cycle, so the write or
    // read-data update lands on the edge that enters DONE.
    assign ram_en = (state == ST_ACCESS) && (cnt == '0);

`ifdef MEM_PARITY_EN
    assign ram_wd = {even_par(wd_q), wd_q};
    assign bus.parity_err = mfc_q && !wr_q &&
        (ram_q[DATA_W] ^ even_par(ram_q[DATA_W-1:0]));
`else
    assign ram_wd = wd_q;
    assign bus.parity_err = 1'b0;
`endif

    assign bus.Mdatain = ram_q[DATA_W-1:0];
    assign bus.MFC     = mfc_q;
    assign bus.busy    = busy_q;

    mem_array #(
        .W  (RW),
        .AW (ADDR_W)
    ) u_ram (
        .clock (clock),
        .clear (clear),
        .en    (ram_en),
        .we    (wr_q),
        .addr  (addr_q),
        .wdata (ram_wd),
        .rdata (ram_q)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            addr_q <= '0;
            wd_q   <= '0;
            wr_q   <= 1'b0;
            mfc_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            mfc_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.Read || bus.Write) begin
                        addr_q <= bus.addr;
                        wd_q   <= bus.wdata;
                        wr_q   <= bus.Write && !bus.Read;
                        cnt    <= MEM_CNT_W'(WAIT_STATES);
                        state  <= ST_ACCESS;
                        busy_q <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == '0) begin
                        state <= ST_DONE;
                        mfc_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    // Held strobes must drop before a new request is taken.
                    if (!bus.Read && !bus.Write) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: WAIT_STATES=1 and WAIT_STATES=0 copies.
// Driver pushes expectations; negedge monitors pop them on each MFC pulse.
module tb_mem_responder;

    logic        clock;
    logic        clear;
    int unsigned cyc;
    int          n_chk;
    int          n_fail;

    typedef struct {
        logic [31:0] d;
        bit          rd;
        bit          par;
        int unsigned cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    logic prev_a;
    logic prev_b;

    mem_responder_if #(.DATA_W(32), .ADDR_W(9)) ba ();
    mem_responder_if #(.DATA_W(32), .ADDR_W(9)) bb ();

    mem_responder #(
        .DATA_W(32), .ADDR_W(9), .WAIT_STATES(1)
    ) dut_a (
        .clock (clock),
        .clear (clear),
        .bus   (ba.slave)
    );

    mem_responder #(
        .DATA_W(32), .ADDR_W(9), .WAIT_STATES(0)
    ) dut_b (
        .clock (clock),
        .clear (clear),
        .bus   (bb.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic mon(input string u, input logic mfc, input logic prev,
                       input logic [31:0] md, input logic pe,
                       inout exp_t q[$]);
        exp_t e;
        if (!clear || !mfc) return;
        chk({u, "_mfc_one_cycle"}, 32'(prev), 32'd0);
        if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_unexpected_mfc: got pulse at cycle %0d expected none",
                     u, cyc);
            return;
        end
        e = q.pop_front();
        chk({u, "_latency"}, cyc, e.cyc);
        if (e.rd) chk({u, "_rdata"}, md, e.d);
        chk({u, "_parity_err"}, 32'(pe), 32'(e.par));
    endtask

    always @(negedge clock) begin
        mon("A", ba.MFC, prev_a, ba.Mdatain, ba.parity_err, qa);
        mon("B", bb.MFC, prev_b, bb.Mdatain, bb.parity_err, qb);
        prev_a = ba.MFC;
        prev_b = bb.MFC;
    end

    function automatic logic mfc_of(input int u);
        return (u == 0) ? ba.MFC : bb.MFC;
    endfunction

    function automatic logic busy_of(input int u);
        return (u == 0) ? ba.busy : bb.busy;
    endfunction

    task automatic drive(input int u, input logic rd, input logic wr,
                         input logic [8:0] a, input logic [31:0] d);
        if (u == 0) begin
            ba.Read = rd; ba.Write = wr; ba.addr = a; ba.wdata = d;
        end else begin
            bb.Read = rd; bb.Write = wr; bb.addr = a; bb.wdata = d;
        end
    endtask

    // One complete strobe/MFC transaction; hold keeps the strobe up after MFC.
    task automatic op(input int u, input logic rd, input logic wr,
                      input logic [8:0] a, input logic [31:0] d,
                      input logic [31:0] ed, input bit ep, input int hold);
        exp_t e;
        int   n;
        @(posedge clock); #1;
        e.d   = ed;
        e.rd  = rd;
        e.par = ep;
        e.cyc = cyc + ((u == 0) ? 32'd1 : 32'd0) + 32'd2;
        if (u == 0) qa.push_back(e);
        else        qb.push_back(e);
        drive(u, rd, wr, a, d);
        @(posedge clock); #1;
        drive(u, rd, wr, ~a, ~d);
        n = 0;
        while (!mfc_of(u) && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (n >= 40) begin
            n_chk++; n_fail++;
            $display("FAIL mfc_timeout: got no MFC in 40 cycles expected MFC");
        end
        repeat (hold) @(posedge clock);
        if (hold > 0) begin
            @(negedge clock);
            chk("busy_in_release", 32'(busy_of(u)), 32'd1);
        end
        @(posedge clock); #1;
        drive(u, 1'b0, 1'b0, ~a, ~d);
        n = 0;
        while (busy_of(u) && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (n >= 40) begin
            n_chk++; n_fail++;
            $display("FAIL busy_timeout: got busy=1 after 40 cycles expected 0");
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        prev_a = 1'b0;
        prev_b = 1'b0;
        clear  = 1'b0;
        drive(0, 1'b0, 1'b0, 9'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 9'h0, 32'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_mdatain", ba.Mdatain, 32'h0);
        chk("rst_mfc", 32'(ba.MFC), 32'd0);
        chk("rst_busy", 32'(ba.busy), 32'd0);
        chk("rst_parity", 32'(ba.parity_err), 32'd0);
        clear = 1'b1;

        // Write then read, both at WAIT_STATES=1.
        op(0, 1'b0, 1'b1, 9'h010, 32'h0000_0005, 32'h0, 1'b0, 0);
        op(0, 1'b1, 1'b0, 9'h010, 32'h0, 32'h0000_0005, 1'b0, 0);
        op(0, 1'b0, 1'b1, 9'h011, 32'h0000_0099, 32'h0, 1'b0, 0);
        chk("mdatain_hold_on_write", ba.Mdatain, 32'h0000_0005);

        // Held read: one pulse only; a new read pulses again.
        op(0, 1'b1, 1'b0, 9'h011, 32'h0, 32'h0000_0099, 1'b0, 5);
        op(0, 1'b1, 1'b0, 9'h010, 32'h0, 32'h0000_0005, 1'b0, 0);

        // Read and Write together: read wins, RAM untouched.
        op(0, 1'b0, 1'b1, 9'h020, 32'h0000_0067, 32'h0, 1'b0, 0);
        op(0, 1'b1, 1'b1, 9'h020, 32'hFFFF_FFFF, 32'h0000_0067, 1'b0, 0);
        op(0, 1'b1, 1'b0, 9'h020, 32'h0, 32'h0000_0067, 1'b0, 0);

        // Address boundaries.
        op(0, 1'b0, 1'b1, 9'h1FF, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
        op(0, 1'b0, 1'b1, 9'h000, 32'hA5A5_0001, 32'h0, 1'b0, 0);
        op(0, 1'b1, 1'b0, 9'h1FF, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
        op(0, 1'b1, 1'b0, 9'h000, 32'h0, 32'hA5A5_0001, 1'b0, 0);

        // Reset in the last ACCESS cycle discards the write.
        op(0, 1'b0, 1'b1, 9'h030, 32'h0000_0011, 32'h0, 1'b0, 0);
        @(posedge clock); #1;
        drive(0, 1'b0, 1'b1, 9'h030, 32'h0000_00AA);
        @(posedge clock); #1;
        @(posedge clock); #1;
        clear = 1'b0;
        @(negedge clock);
        chk("abort_mfc", 32'(ba.MFC), 32'd0);
        chk("abort_busy", 32'(ba.busy), 32'd0);
        chk("abort_mdatain", ba.Mdatain, 32'h0);
        drive(0, 1'b0, 1'b0, 9'h0, 32'h0);
        @(posedge clock); #1;
        clear = 1'b1;
        op(0, 1'b1, 1'b0, 9'h030, 32'h0, 32'h0000_0011, 1'b0, 0);

        // Zero wait states.
        op(1, 1'b0, 1'b1, 9'h1FF, 32'h112B_0000, 32'h0, 1'b0, 0);
        op(1, 1'b1, 1'b0, 9'h1FF, 32'h0, 32'h112B_0000, 1'b0, 0);
        op(1, 1'b0, 1'b1, 9'h010, 32'h0000_0033, 32'h0, 1'b0, 0);
        op(1, 1'b1, 1'b0, 9'h010, 32'h0, 32'h0000_0033, 1'b0, 0);

`ifdef MEM_PARITY_EN
        op(0, 1'b0, 1'b1, 9'h010, 32'h0000_0010, 32'h0, 1'b0, 0);
        dut_a.u_ram.mem[16][32] = ~dut_a.u_ram.mem[16][32];
        op(0, 1'b1, 1'b0, 9'h010, 32'h0, 32'h0000_0010, 1'b1, 0);
`endif

        repeat (4) @(posedge clock);
        @(negedge clock);
        chk("scoreboard_drained", 32'(qa.size() + qb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
